// File: rtl/golomb_bit_packer.sv
// golomb_bit_packer
//   Consumer end of the encoder's code pipeline. Builds JPEG-LS limited-length
//   Golomb codes from (k, glimit, EMErrval), merges them with pre-formed
//   run-mode codes and packs every bit MSB-first into 32-bit words. A flush
//   sequence drains in-flight codes and zero-pads the final partial word.
//
// Ports
//   clk             in   rising-edge clock
//   reset           in   asynchronous, active-low reset
//   en_run_in       in   run code valid this cycle
//   codes_r_in      in   [31:0] run code, right-aligned
//   codes_r_len_in  in   [5:0]  run code length 0..32 (0 = no bits)
//   en_golomb_in    in   Golomb parameters valid this cycle
//   k_in            in   [4:0]  Golomb parameter k
//   glimit_in       in   [5:0]  LIMIT (maximum code length)
//   EMErrval_in     in   [8:0]  mapped error value
//   flush_in        in   end-of-image pulse
//   word_out        out  [31:0] packed word, first bit in bit 31
//   word_valid      out  one-cycle pulse per word
//   flush_done      out  one-cycle pulse when the flush completes
//   err_out         out  sticky: overflow / bad length / input during flush
module golomb_bit_packer #(
  parameter int QBPP  = 8,
  parameter int ACC_W = 96   // must exceed 64 (one cycle can append 64 bits)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en_run_in,
  input  logic [31:0] codes_r_in,
  input  logic [5:0]  codes_r_len_in,
  input  logic        en_golomb_in,
  input  logic [4:0]  k_in,
  input  logic [5:0]  glimit_in,
  input  logic [8:0]  EMErrval_in,
  input  logic        flush_in,
  output logic [31:0] word_out,
  output logic        word_valid,
  output logic        flush_done,
  output logic        err_out
);

  localparam int FILL_W = $clog2(ACC_W + 1);
  localparam int CW     = FILL_W + 1;  // wide enough for fill + 64 incoming bits

  typedef enum logic [1:0] {ST_ACTIVE = 2'd0, ST_DRAIN = 2'd1, ST_PAD = 2'd2} state_t;
  state_t state_q, state_d;

  logic accept_in, pad_now, ignored_in;

  // Stage-1 code formation
  logic [8:0]  q_val;
  logic        is_regular;
  logic [9:0]  glen_c;
  logic [31:0] gcode_c, rcode_c;
  logic        run_bad, gol_bad;
  logic [31:0] run_code_q, run_code_d, gol_code_q, gol_code_d;
  logic [5:0]  run_len_q, run_len_d, gol_len_q, gol_len_d;

  // Stage-2 accumulator; pending bits are kept left-aligned at the top of acc
  logic [ACC_W-1:0]  acc_q, acc_d, acc_base, ins_bits;
  logic [FILL_W-1:0] fill_q, fill_d, fill_base;
  logic [CW-1:0]     app_len, total_len, shamt;
  logic [63:0]       merged;
  logic              emit, ovf;

  logic [31:0] word_q, word_d;
  logic        word_valid_q, word_valid_d;
  logic        flush_done_q, flush_done_d;
  logic        err_q, err_d;

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ACTIVE: if (flush_in) state_d = ST_DRAIN;
      // Leave DRAIN once no whole word remains and nothing is in flight.
      ST_DRAIN:  if (!emit && run_len_q == 6'd0 && gol_len_q == 6'd0) state_d = ST_PAD;
      ST_PAD:    state_d = ST_ACTIVE;
      default:   state_d = ST_ACTIVE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    accept_in  = (state_q == ST_ACTIVE);
    pad_now    = (state_q == ST_PAD);
    ignored_in = !accept_in && (en_run_in || en_golomb_in || flush_in);
  end

  // ---------------- Stage 1: code formation ----------------
  always_comb begin
    q_val = EMErrval_in >> k_in;
    // q < glimit-QBPP-1 rewritten as an unsigned compare so small glimit cannot wrap.
    is_regular = ({1'b0, q_val} + 10'(QBPP + 1)) < {4'b0, glimit_in};
    if (is_regular) begin
      // q zeros, a '1', then the k LSBs: the '1' sits at bit k of a (q+k+1)-bit field.
      gcode_c = (32'd1 << k_in) |
                (32'(EMErrval_in) & (32'hFFFF_FFFF >> (6'd32 - {1'b0, k_in})));
      glen_c  = 10'(q_val) + 10'(k_in) + 10'd1;
    end else begin
      gcode_c = (32'd1 << QBPP) | (32'(EMErrval_in - 9'd1) & ((32'd1 << QBPP) - 32'd1));
      glen_c  = 10'(glimit_in);
    end
    run_bad = en_run_in && (codes_r_len_in > 6'd32);
    gol_bad = en_golomb_in && (glen_c > 10'd32);
    // Clear any bits above the stated run length so they cannot corrupt the merge.
    rcode_c = codes_r_in & (32'hFFFF_FFFF >> (6'd32 - codes_r_len_in));

    run_code_d = '0;
    run_len_d  = '0;
    gol_code_d = '0;
    gol_len_d  = '0;
    if (accept_in && en_run_in && !run_bad) begin
      run_code_d = rcode_c;
      run_len_d  = codes_r_len_in;
    end
    if (accept_in && en_golomb_in && !gol_bad) begin
      gol_code_d = gcode_c;
      gol_len_d  = glen_c[5:0];
    end
  end

  // ---------------- Stage 2: append and emit ----------------
  always_comb begin
    emit      = (fill_q >= FILL_W'(32));
    fill_base = emit ? fill_q - FILL_W'(32) : fill_q;
    acc_base  = emit ? (acc_q << 32) : acc_q;
    // Run bits precede Golomb bits in the merged right-aligned field.
    merged    = ({32'd0, run_code_q} << gol_len_q) | {32'd0, gol_code_q};
    app_len   = CW'(run_len_q) + CW'(gol_len_q);
    total_len = CW'(fill_base) + app_len;
    ovf       = (total_len > CW'(ACC_W));
    shamt     = CW'(ACC_W) - total_len;
    ins_bits  = {{(ACC_W-64){1'b0}}, merged} << shamt;

    acc_d        = acc_base;
    fill_d       = fill_base;
    word_d       = word_q;
    word_valid_d = 1'b0;
    flush_done_d = 1'b0;
    err_d        = err_q | run_bad | gol_bad | ignored_in;

    if (emit) begin
      word_d       = acc_q[ACC_W-1 -: 32];
      word_valid_d = 1'b1;
    end

    if (pad_now) begin
      // Bits below fill are always zero, so the top slice is already padded.
      if (fill_q != '0) begin
        word_d       = acc_q[ACC_W-1 -: 32];
        word_valid_d = 1'b1;
      end
      flush_done_d = 1'b1;
      acc_d        = '0;
      fill_d       = '0;
    end else if (ovf) begin
      err_d = 1'b1;
    end else begin
      acc_d  = acc_base | ins_bits;
      fill_d = total_len[FILL_W-1:0];
    end
  end

  // ---------------- Registers ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_ACTIVE;
      run_code_q   <= '0;
      run_len_q    <= '0;
      gol_code_q   <= '0;
      gol_len_q    <= '0;
      acc_q        <= '0;
      fill_q       <= '0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
      flush_done_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      run_code_q   <= run_code_d;
      run_len_q    <= run_len_d;
      gol_code_q   <= gol_code_d;
      gol_len_q    <= gol_len_d;
      acc_q        <= acc_d;
      fill_q       <= fill_d;
      word_q       <= word_d;
      word_valid_q <= word_valid_d;
      flush_done_q <= flush_done_d;
      err_q        <= err_d;
    end
  end

  assign word_out   = word_q;
  assign word_valid = word_valid_q;
  assign flush_done = flush_done_q;
  assign err_out    = err_q;

endmodule

// File: tb/tb_golomb_bit_packer.sv
module tb_golomb_bit_packer;

  logic        clk = 1'b0;
  logic        reset;
  logic        en_run_in;
  logic [31:0] codes_r_in;
  logic [5:0]  codes_r_len_in;
  logic        en_golomb_in;
  logic [4:0]  k_in;
  logic [5:0]  glimit_in;
  logic [8:0]  EMErrval_in;
  logic        flush_in;
  logic [31:0] word_out;
  logic        word_valid;
  logic        flush_done;
  logic        err_out;

  always #5 clk = ~clk;

  golomb_bit_packer #(.QBPP(8), .ACC_W(96)) dut (
    .clk            (clk),
    .reset          (reset),
    .en_run_in      (en_run_in),
    .codes_r_in     (codes_r_in),
    .codes_r_len_in (codes_r_len_in),
    .en_golomb_in   (en_golomb_in),
    .k_in           (k_in),
    .glimit_in      (glimit_in),
    .EMErrval_in    (EMErrval_in),
    .flush_in       (flush_in),
    .word_out       (word_out),
    .word_valid     (word_valid),
    .flush_done     (flush_done),
    .err_out        (err_out)
  );

  int checks = 0;
  int errors = 0;

  // Output monitor, sampled on the inactive edge.
  logic [31:0] wq[$];
  int fd_cnt      = 0;
  int fd_word_cnt = 0;
  always @(negedge clk) begin
    if (word_valid) wq.push_back(word_out);
    if (flush_done) begin
      fd_cnt++;
      if (word_valid) fd_word_cnt++;
    end
  end

  typedef struct packed {
    logic        en_r;
    logic [31:0] rc;
    logic [5:0]  rl;
    logic        en_g;
    logic [4:0]  k;
    logic [5:0]  gl;
    logic [8:0]  ev;
    logic        pad;       // 1: word appears together with flush_done
    logic [31:0] exp_word;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    en_run_in      = 1'b0;
    codes_r_in     = '0;
    codes_r_len_in = '0;
    en_golomb_in   = 1'b0;
    k_in           = '0;
    glimit_in      = 6'd32;
    EMErrval_in    = '0;
    flush_in       = 1'b0;
  endtask

  task automatic wait_fd(input int start, input string name);
    for (int n = 0; n < 40 && fd_cnt == start; n++) begin
      @(negedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    check(name, 32'(fd_cnt - start), 32'd1);
  endtask

  task automatic do_flush(input string name);
    int start;
    start    = fd_cnt;
    flush_in = 1'b1;
    step();
    flush_in = 1'b0;
    wait_fd(start, name);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] got;
    logic [31:0] exp;
    int fdw0;
    int fd0;

    vecs[0]  = '{1'b1, 32'h0000ABCD, 6'd16, 1'b0, 5'd0, 6'd32, 9'd0,   1'b1, 32'hABCD0000};
    vecs[1]  = '{1'b0, 32'h0,        6'd0,  1'b1, 5'd0, 6'd32, 9'd100, 1'b0, 32'h00000163};
    vecs[2]  = '{1'b1, 32'h0000000F, 6'd4,  1'b1, 5'd9, 6'd32, 9'd0,   1'b1, 32'hF8000000};
    vecs[3]  = '{1'b0, 32'h0,        6'd0,  1'b1, 5'd2, 6'd32, 9'd13,  1'b1, 32'h14000000};
    vecs[4]  = '{1'b0, 32'h0,        6'd0,  1'b1, 5'd3, 6'd32, 9'd10,  1'b1, 32'h50000000};
    vecs[5]  = '{1'b1, 32'hFFFFFFFF, 6'd0,  1'b1, 5'd0, 6'd32, 9'd0,   1'b1, 32'h80000000};
    vecs[6]  = '{1'b1, 32'hFFFFFFF5, 6'd4,  1'b0, 5'd0, 6'd32, 9'd0,   1'b1, 32'h50000000};
    vecs[7]  = '{1'b0, 32'h0,        6'd0,  1'b1, 5'd4, 6'd32, 9'd400, 1'b0, 32'h0000018F};
    vecs[8]  = '{1'b0, 32'h0,        6'd0,  1'b1, 5'd0, 6'd32, 9'd22,  1'b1, 32'h00000200};
    vecs[9]  = '{1'b0, 32'h0,        6'd0,  1'b1, 5'd0, 6'd32, 9'd23,  1'b0, 32'h00000116};
    vecs[10] = '{1'b0, 32'h0,        6'd0,  1'b1, 5'd1, 6'd20, 9'd30,  1'b1, 32'h0011D000};
    vecs[11] = '{1'b1, 32'h12345678, 6'd32, 1'b0, 5'd0, 6'd32, 9'd0,   1'b0, 32'h12345678};
    vecs[12] = '{1'b1, 32'h00000003, 6'd2,  1'b1, 5'd1, 6'd32, 9'd3,   1'b1, 32'hD8000000};

    clear_inputs();
    reset = 1'b0;
    @(negedge clk);
    check("rst_word_out",   word_out,   32'h0);
    check("rst_word_valid", 32'(word_valid), 32'h0);
    check("rst_flush_done", 32'(flush_done), 32'h0);
    check("rst_err_out",    32'(err_out),    32'h0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    step();

    // ---- table-driven single-transaction vectors, each followed by a flush ----
    for (int i = 0; i < 13; i++) begin
      wq.delete();
      fdw0           = fd_word_cnt;
      en_run_in      = vecs[i].en_r;
      codes_r_in     = vecs[i].rc;
      codes_r_len_in = vecs[i].rl;
      en_golomb_in   = vecs[i].en_g;
      k_in           = vecs[i].k;
      glimit_in      = vecs[i].gl;
      EMErrval_in    = vecs[i].ev;
      step();
      clear_inputs();
      do_flush($sformatf("vec%0d_flush_done", i));
      check($sformatf("vec%0d_nwords", i), 32'(wq.size()), 32'd1);
      got = (wq.size() > 0) ? wq[0] : 32'hxxxxxxxx;
      check($sformatf("vec%0d_word", i), got, vecs[i].exp_word);
      check($sformatf("vec%0d_pad", i), 32'(fd_word_cnt - fdw0), 32'(vecs[i].pad));
      check($sformatf("vec%0d_err", i), 32'(err_out), 32'h0);
    end

    // ---- two run codes back to back: word and its latency ----
    wq.delete();
    en_run_in = 1'b1; codes_r_in = 32'h0000ABCD; codes_r_len_in = 6'd16;
    step();
    step();
    clear_inputs();
    @(negedge clk);
    check("lat_edge1_valid", 32'(word_valid), 32'h0);
    @(negedge clk);
    check("lat_edge2_valid", 32'(word_valid), 32'h0);
    @(negedge clk);
    check("lat_edge3_valid", 32'(word_valid), 32'h1);
    check("lat_edge3_word", word_out, 32'hABCDABCD);
    @(negedge clk);
    check("lat_pulse_end", 32'(word_valid), 32'h0);
    @(posedge clk);
    #1;

    // ---- two Golomb codes then flush: padded word with flush_done ----
    wq.delete();
    fdw0 = fd_word_cnt;
    en_golomb_in = 1'b1; k_in = 5'd2; EMErrval_in = 9'd13;
    step();
    k_in = 5'd0; EMErrval_in = 9'd5;
    step();
    clear_inputs();
    do_flush("pad_flush_done");
    check("pad_nwords", 32'(wq.size()), 32'd1);
    got = (wq.size() > 0) ? wq[0] : 32'hxxxxxxxx;
    check("pad_word", got, 32'h14100000);
    check("pad_same_cycle", 32'(fd_word_cnt - fdw0), 32'd1);

    // ---- flush with nothing pending ----
    wq.delete();
    fdw0 = fd_word_cnt;
    do_flush("empty_flush_done");
    check("empty_nwords", 32'(wq.size()), 32'd0);
    check("empty_no_word_pulse", 32'(fd_word_cnt - fdw0), 32'd0);

    // ---- overflow: 64 bits offered every cycle ----
    wq.delete();
    for (int c = 0; c < 8; c++) begin
      en_run_in = 1'b1; codes_r_in = 32'hDEADBEEF; codes_r_len_in = 6'd32;
      en_golomb_in = 1'b1; k_in = 5'd0; glimit_in = 6'd32; EMErrval_in = 9'd100;
      step();
    end
    clear_inputs();
    do_flush("ovf_flush_done");
    check("ovf_err", 32'(err_out), 32'h1);
    check("ovf_nwords", 32'(wq.size()), 32'd10);
    for (int i = 0; i < 10; i++) begin
      exp = (i % 2 == 0) ? 32'hDEADBEEF : 32'h00000163;
      got = (i < wq.size()) ? wq[i] : 32'hxxxxxxxx;
      check($sformatf("ovf_word%0d", i), got, exp);
    end

    // ---- reset asserted during DRAIN ----
    en_run_in = 1'b1; codes_r_in = 32'h0000ABCD; codes_r_len_in = 6'd16;
    step();
    clear_inputs();
    flush_in = 1'b1;
    step();
    flush_in = 1'b0;
    wq.delete();
    fd0 = fd_cnt;
    reset = 1'b0;
    @(negedge clk);
    check("rstdrain_word_out",   word_out,        32'h0);
    check("rstdrain_word_valid", 32'(word_valid), 32'h0);
    check("rstdrain_flush_done", 32'(flush_done), 32'h0);
    check("rstdrain_err_out",    32'(err_out),    32'h0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (6) step();
    check("rstdrain_no_flush_done", 32'(fd_cnt - fd0), 32'd0);
    check("rstdrain_no_words", 32'(wq.size()), 32'd0);

    // ---- run length 33: dropped, sticky error ----
    wq.delete();
    en_run_in = 1'b1; codes_r_in = 32'hFFFFFFFF; codes_r_len_in = 6'd33;
    step();
    clear_inputs();
    check("badrun_err", 32'(err_out), 32'h1);
    do_flush("badrun_flush_done");
    check("badrun_nwords", 32'(wq.size()), 32'd0);
    do_reset();

    // ---- Golomb length 40 dropped, run slot of same cycle kept ----
    wq.delete();
    en_run_in = 1'b1; codes_r_in = 32'h0000000A; codes_r_len_in = 6'd4;
    en_golomb_in = 1'b1; k_in = 5'd0; glimit_in = 6'd40; EMErrval_in = 9'd100;
    step();
    clear_inputs();
    check("badgol_err", 32'(err_out), 32'h1);
    do_flush("badgol_flush_done");
    check("badgol_nwords", 32'(wq.size()), 32'd1);
    got = (wq.size() > 0) ? wq[0] : 32'hxxxxxxxx;
    check("badgol_word", got, 32'hA0000000);
    do_reset();

    // ---- input offered during DRAIN is ignored and flagged ----
    wq.delete();
    check("drainin_err_before", 32'(err_out), 32'h0);
    fd0 = fd_cnt;
    flush_in = 1'b1;
    step();
    flush_in = 1'b0;
    en_golomb_in = 1'b1; k_in = 5'd0; EMErrval_in = 9'd0;
    step();
    clear_inputs();
    check("drainin_err", 32'(err_out), 32'h1);
    wait_fd(fd0, "drainin_flush_done");
    check("drainin_nwords", 32'(wq.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
